// File: rtl/scale_pkg.sv
// rtl/scale_pkg.sv - shared types and constants for the gram-to-kilogram converter
package scale_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int GRAMS_PER_KG = 1000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// rtl/seq_restoring_div.sv - bit-serial restoring divider, one quotient bit per cycle MSB first
module seq_restoring_div
  import scale_pkg::*;
#(
  parameter int W_IN    = 14,
  parameter int DIVISOR = GRAMS_PER_KG,
  parameter int FRAC_W  = clog2(DIVISOR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_IN-1:0]   dividend,
  output logic              busy,
  output logic              done,
  output logic [W_IN-1:0]   quotient,
  output logic [FRAC_W-1:0] remainder
);

  localparam int CNT_W = (clog2(W_IN) > 0) ? clog2(W_IN) : 1;
  localparam logic [FRAC_W:0] DIV_C = (FRAC_W + 1)'(DIVISOR);

  logic [FRAC_W-1:0] rem_q, rem_d;
  logic [W_IN-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [FRAC_W:0]   trial;
  logic [FRAC_W-1:0] diff;
  logic              fits;

  // quo_q doubles as the dividend shifter: dividend bits leave at the top while
  // quotient bits enter at the bottom, so it holds the quotient after W_IN steps.
  always_comb begin
    trial  = {rem_q, quo_q[W_IN-1]};
    fits   = (trial >= DIV_C);
    diff   = trial[FRAC_W-1:0] - DIV_C[FRAC_W-1:0];
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      cnt_d  = CNT_W'(W_IN - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = fits ? diff : trial[FRAC_W-1:0];
      quo_d = {quo_q[W_IN-2:0], fits};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/weight_kg_converter_seq.sv
// rtl/weight_kg_converter_seq.sv - handshaked grams-to-kg converter with tare, sign and overload
module weight_kg_converter_seq
  import scale_pkg::*;
#(
  parameter int W_IN      = 14,
  parameter int DIVISOR   = GRAMS_PER_KG,
  parameter int FRAC_W    = clog2(DIVISOR),
  parameter int MAX_GRAMS = 15000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IN-1:0]   weightInGrams,
  input  logic              tare_load,
  input  logic              tare_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_IN-1:0]   weightKgInteger,
  output logic [FRAC_W-1:0] weightKgFraction,
  output logic              weightNegative,
  output logic              overload
);

  localparam logic [31:0] MAX_C = 32'(MAX_GRAMS);

  state_e state_q, state_d;

  logic [W_IN-1:0]   raw_q, raw_d;
  logic [W_IN-1:0]   tare_q, tare_d;
  logic              ovl_q, ovl_d;
  logic              neg_q, neg_d;
  logic [W_IN-1:0]   int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;

  logic              accept;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [W_IN-1:0]   div_quo;
  logic [FRAC_W-1:0] div_rem;
  logic signed [W_IN:0] net;
  logic [W_IN-1:0]   net_mag;

  assign accept  = in_valid && in_ready;
  assign net     = $signed({1'b0, raw_q}) - $signed({1'b0, tare_q});
  assign net_mag = net[W_IN] ? W_IN'(-net) : W_IN'(net);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !tare_load) state_d = SUB;
      SUB:  state_d = DIV;
      DIV:  if (div_done && !div_busy) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    div_start = (state_q == SUB);
  end

  // tare_load is applied after tare_clear so it wins when both arrive together.
  always_comb begin
    raw_d  = raw_q;
    tare_d = tare_q;
    ovl_d  = ovl_q;
    neg_d  = neg_q;
    int_d  = int_q;
    frac_d = frac_q;
    if (tare_clear) tare_d = '0;
    if (accept && tare_load) tare_d = weightInGrams;
    if (accept && !tare_load) begin
      raw_d = weightInGrams;
      ovl_d = (32'(weightInGrams) > MAX_C);
    end
    if (state_q == SUB) neg_d = net[W_IN];
    if (state_q == DIV && div_done) begin
      int_d  = div_quo;
      frac_d = div_rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= '0;
      tare_q <= '0;
      ovl_q  <= 1'b0;
      neg_q  <= 1'b0;
      int_q  <= '0;
      frac_q <= '0;
    end else begin
      raw_q  <= raw_d;
      tare_q <= tare_d;
      ovl_q  <= ovl_d;
      neg_q  <= neg_d;
      int_q  <= int_d;
      frac_q <= frac_d;
    end
  end

  seq_restoring_div #(
    .W_IN    (W_IN),
    .DIVISOR (DIVISOR),
    .FRAC_W  (FRAC_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (net_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign weightKgInteger  = int_q;
  assign weightKgFraction = frac_q;
  assign weightNegative   = neg_q;
  assign overload         = ovl_q;

endmodule

// File: tb/tb_weight_kg_converter_seq.sv
// tb/tb_weight_kg_converter_seq.sv - scoreboard bench for weight_kg_converter_seq
module tb_weight_kg_converter_seq;

  typedef struct packed {
    logic [13:0] q;
    logic [9:0]  r;
    logic        neg;
    logic        ovl;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] weightInGrams;
  logic        tare_load;
  logic        tare_clear;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] weightKgInteger;
  logic [9:0]  weightKgFraction;
  logic        weightNegative;
  logic        overload;

  int   checks = 0;
  int   errors = 0;
  int   tare_m = 0;
  res_t exp_q[$];

  weight_kg_converter_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .weightInGrams    (weightInGrams),
    .tare_load        (tare_load),
    .tare_clear       (tare_clear),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .weightKgInteger  (weightKgInteger),
    .weightKgFraction (weightKgFraction),
    .weightNegative   (weightNegative),
    .overload         (overload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int raw, input int tare);
    res_t r;
    int   net;
    int   mag;
    net   = raw - tare;
    mag   = (net < 0) ? -net : net;
    r.q   = 14'(mag / 1000);
    r.r   = 10'(mag % 1000);
    r.neg = (net < 0);
    r.ovl = (raw > 15000);
    return r;
  endfunction

  function automatic res_t observed();
    return {weightKgInteger, weightKgFraction, weightNegative, overload};
  endfunction

  task automatic wait_in_ready();
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic run_conv(input int raw, output res_t got, output int lat);
    @(negedge clk);
    in_valid      = 1'b1;
    tare_load     = 1'b0;
    weightInGrams = 14'(raw);
    wait_in_ready();
    exp_q.push_back(model(raw, tare_m));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = observed();
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_tare(input int val, input bit clr);
    @(negedge clk);
    in_valid      = 1'b1;
    tare_load     = 1'b1;
    tare_clear    = clr;
    weightInGrams = 14'(val);
    wait_in_ready();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    tare_load  = 1'b0;
    tare_clear = 1'b0;
    tare_m     = val;
  endtask

  task automatic do_tare_clear();
    @(negedge clk);
    tare_clear = 1'b1;
    @(posedge clk);
    #1;
    tare_clear = 1'b0;
    tare_m     = 0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    tare_load     = 1'b0;
    tare_clear    = 1'b0;
    out_ready     = 1'b1;
    weightInGrams = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (observed() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", observed());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int   vals[7] = '{1500, 999, 0, 1000, 15000, 15001, 16383};
    res_t got;
    res_t exp;
    int   lat;
    foreach (vals[i]) begin
      run_conv(vals[i], got, lat);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_%0d: got q=%0d r=%0d neg=%0b ovl=%0b required q=%0d r=%0d neg=%0b ovl=%0b",
                 vals[i], got.q, got.r, got.neg, got.ovl, exp.q, exp.r, exp.neg, exp.ovl);
      end
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL basic_latency_%0d: got %0d required 16", vals[i], lat);
      end
    end
  endtask

  task automatic test_tare();
    int   taremode[4] = '{200, 2000, -1, 300};
    res_t got;
    res_t exp;
    int   lat;
    foreach (taremode[i]) begin
      if (taremode[i] < 0) begin
        do_tare_clear();
      end else begin
        load_tare(taremode[i], (i == 3));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL tare_load_no_result: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
      end
      run_conv(1500, got, lat);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL tare_step%0d: got q=%0d r=%0d neg=%0b ovl=%0b required q=%0d r=%0d neg=%0b ovl=%0b",
                 i, got.q, got.r, got.neg, got.ovl, exp.q, exp.r, exp.neg, exp.ovl);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t got;
    res_t exp;
    int   lat;
    int   spurious;
    out_ready = 1'b0;
    run_conv(3456, got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || lat !== 16) begin
      errors++;
      $display("FAIL bp_result: got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=16", got.q, got.r, lat, exp.q, exp.r);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid      = 1'b1;
      weightInGrams = 14'($urandom_range(0, 16383));
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== got) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%0b in_ready=%0b data=%h required 1/0/%h",
                 i, out_valid, in_ready, observed(), got);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL bp_ignored_pulses: out_valid cycles=%0d required 0", spurious);
    end
  endtask

  task automatic test_reset_mid_div();
    res_t got;
    res_t exp;
    int   lat;
    load_tare(700, 1'b0);
    @(negedge clk);
    in_valid      = 1'b1;
    weightInGrams = 14'd1500;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== res_t'(0)) begin
      errors++;
      $display("FAIL mid_div_reset: out_valid=%0b in_ready=%0b data=%h required 0/1/0", out_valid, in_ready, observed());
    end
    @(negedge clk);
    rst_n  = 1'b1;
    tare_m = 0;
    run_conv(1500, got, lat);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_div_after: got q=%0d r=%0d neg=%0b required q=%0d r=%0d neg=%0b",
               got.q, got.r, got.neg, exp.q, exp.r, exp.neg);
    end
  endtask

  task automatic test_random();
    res_t got;
    res_t exp;
    int   lat;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_tare_clear();
      else load_tare(int'($urandom_range(0, 16383)), 1'b0);
      run_conv(int'($urandom_range(0, 16383)), got, lat);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat !== 16) begin
        errors++;
        $display("FAIL random_%0d: got q=%0d r=%0d neg=%0b ovl=%0b lat=%0d required q=%0d r=%0d neg=%0b ovl=%0b lat=16",
                 i, got.q, got.r, got.neg, got.ovl, lat, exp.q, exp.r, exp.neg, exp.ovl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tare();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
